// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file.
// Slice helper keeps packed-port indexing consistent across files.
package regfile_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int NREGS_DEF  = 32;
  localparam int NRD_DEF    = 2;
  localparam int NWR_DEF    = 1;
  localparam int BYPASS_DEF = 1;

  typedef enum logic {
    RF_INIT,
    RF_RUN
  } rf_state_e;

  // Low bit of port `port` inside a packed bus of `width`-bit fields.
  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: zero/range check, write-bypass mux and busy mask.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NWR    = NWR_DEF,
  parameter int BYPASS = BYPASS_DEF,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic               run,
  input  logic [AW-1:0]      addr,
  input  logic [NWR-1:0]     wr_en,
  input  logic [NWR*AW-1:0]  wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic [XLEN-1:0]    rf_data,
  input  logic               pending,
  output logic [XLEN-1:0]    data,
  output logic               busy
);

  localparam logic [AW:0] NREGS_L = (AW+1)'(NREGS);

  logic            valid;
  logic            hit;
  logic [XLEN-1:0] hit_data;

  // Later write ports overwrite earlier matches, so the highest index wins.
  always_comb begin
    data     = '0;
    busy     = 1'b0;
    hit      = 1'b0;
    hit_data = '0;
    valid    = run && (addr != '0) && ({1'b0, addr} < NREGS_L);
    if (BYPASS != 0) begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && (wr_addr[slice_lo(j, AW) +: AW] == addr)) begin
          hit      = 1'b1;
          hit_data = wr_data[slice_lo(j, XLEN) +: XLEN];
        end
      end
    end
    if (valid) begin
      data = hit ? hit_data : rf_data;
      busy = pending && !hit;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with post-reset clear sweep, write bypass and
// a per-register pending scoreboard. The storage array itself has no reset.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NRD    = NRD_DEF,
  parameter int NWR    = NWR_DEF,
  parameter int BYPASS = BYPASS_DEF,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                init_done_o,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]      rd_busy_o,
  input  logic [NWR-1:0]      wr_en_i,
  input  logic [NWR*AW-1:0]   wr_addr_i,
  input  logic [NWR*XLEN-1:0] wr_data_i,
  input  logic                alloc_en_i,
  input  logic [AW-1:0]       alloc_addr_i,
  output logic                wr_conflict_o
);

  localparam logic [AW:0]   NREGS_L  = (AW+1)'(NREGS);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  rf_state_e        state, state_next;
  logic [AW-1:0]    idx, idx_next;
  logic             sweep_we;
  logic             run;
  logic [XLEN-1:0]  rf [NREGS];
  logic [NREGS-1:0] pending, pending_next;
  logic [AW-1:0]    wa [NWR];
  logic [XLEN-1:0]  wd [NWR];
  logic [NWR-1:0]   wr_ok;
  logic             conflict_now;
  logic             alloc_ok;

  assign run         = (state == RF_RUN);
  assign init_done_o = run;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RF_INIT;
      idx   <= AW'(1);
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // Sweep walks idx from 1 up; register 0 never needs clearing.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    sweep_we   = 1'b0;
    if (state == RF_INIT) begin
      sweep_we = 1'b1;
      idx_next = idx + 1'b1;
      if (idx == LAST_IDX) state_next = RF_RUN;
    end
  end

  for (genvar j = 0; j < NWR; j++) begin : g_wr
    assign wa[j]    = wr_addr_i[slice_lo(j, AW) +: AW];
    assign wd[j]    = wr_data_i[slice_lo(j, XLEN) +: XLEN];
    assign wr_ok[j] = run && wr_en_i[j] && (wa[j] != '0) && ({1'b0, wa[j]} < NREGS_L);
  end

  // Later loop iterations take priority, giving highest-port-wins.
  always_ff @(posedge clk) begin
    if (sweep_we) rf[idx] <= '0;
    for (int j = 0; j < NWR; j++) begin
      if (wr_ok[j]) rf[wa[j]] <= wd[j];
    end
  end

  always_comb begin
    conflict_now = 1'b0;
    for (int i = 0; i < NWR; i++) begin
      for (int j = i + 1; j < NWR; j++) begin
        if (wr_ok[i] && wr_ok[j] && (wa[i] == wa[j])) conflict_now = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wr_conflict_o <= 1'b0;
    else      wr_conflict_o <= conflict_now;
  end

  assign alloc_ok = run && alloc_en_i && (alloc_addr_i != '0);

  // Alloc is applied after the write clear so a new producer survives.
  always_comb begin
    pending_next = pending;
    for (int r = 1; r < NREGS; r++) begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_ok[j] && (wa[j] == AW'(r))) pending_next[r] = 1'b0;
      end
      if (alloc_ok && (alloc_addr_i == AW'(r))) pending_next[r] = 1'b1;
    end
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pending <= '0;
    else      pending <= pending_next;
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   ra;
    logic            in_range;
    logic [XLEN-1:0] rf_rd;
    logic            pend_rd;

    assign ra       = rd_addr_i[slice_lo(k, AW) +: AW];
    assign in_range = ({1'b0, ra} < NREGS_L);
    assign rf_rd    = in_range ? rf[ra] : '0;
    assign pend_rd  = in_range ? pending[ra] : 1'b0;

    regfile_rd_port #(
      .XLEN   (XLEN),
      .NREGS  (NREGS),
      .NWR    (NWR),
      .BYPASS (BYPASS),
      .AW     (AW)
    ) u_rd_port (
      .run     (run),
      .addr    (ra),
      .wr_en   (wr_en_i),
      .wr_addr (wr_addr_i),
      .wr_data (wr_data_i),
      .rf_data (rf_rd),
      .pending (pend_rd),
      .data    (rd_data_o[slice_lo(k, XLEN) +: XLEN]),
      .busy    (rd_busy_o[k])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: dut_a is 2R1W without bypass (32 regs), dut_b is 2R2W with
// bypass and 24 regs so out-of-range addresses can be exercised.
module tb_regfile_mp;

  logic clk;
  logic rst;

  logic        a_done, a_conf;
  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic [0:0]  a_wr_en;
  logic [4:0]  a_wr_addr;
  logic [31:0] a_wr_data;
  logic        a_alloc_en;
  logic [4:0]  a_alloc_addr;

  logic        b_done, b_conf;
  logic [9:0]  b_rd_addr;
  logic [63:0] b_rd_data;
  logic [1:0]  b_rd_busy;
  logic [1:0]  b_wr_en;
  logic [9:0]  b_wr_addr;
  logic [63:0] b_wr_data;
  logic        b_alloc_en;
  logic [4:0]  b_alloc_addr;

  int checks;
  int failures;
  int a_edges;
  int b_edges;

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(1), .BYPASS(0)) dut_a (
    .clk(clk), .rst(rst), .init_done_o(a_done),
    .rd_addr_i(a_rd_addr), .rd_data_o(a_rd_data), .rd_busy_o(a_rd_busy),
    .wr_en_i(a_wr_en), .wr_addr_i(a_wr_addr), .wr_data_i(a_wr_data),
    .alloc_en_i(a_alloc_en), .alloc_addr_i(a_alloc_addr), .wr_conflict_o(a_conf)
  );

  regfile_mp #(.XLEN(32), .NREGS(24), .NRD(2), .NWR(2), .BYPASS(1)) dut_b (
    .clk(clk), .rst(rst), .init_done_o(b_done),
    .rd_addr_i(b_rd_addr), .rd_data_o(b_rd_data), .rd_busy_o(b_rd_busy),
    .wr_en_i(b_wr_en), .wr_addr_i(b_wr_addr), .wr_data_i(b_wr_data),
    .alloc_en_i(b_alloc_en), .alloc_addr_i(b_alloc_addr), .wr_conflict_o(b_conf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus();
    a_wr_en = '0; a_wr_addr = '0; a_wr_data = '0; a_alloc_en = 1'b0; a_alloc_addr = '0;
    b_wr_en = '0; b_wr_addr = '0; b_wr_data = '0; b_alloc_en = 1'b0; b_alloc_addr = '0;
  endtask

  initial begin
    checks = 0; failures = 0; a_edges = 0; b_edges = 0;
    rst = 1'b0;
    applyStimulus();
    a_rd_addr = '0; b_rd_addr = '0;
    #2;
    checkOutput("reset_done_a", a_done, 0);
    checkOutput("reset_done_b", b_done, 0);
    checkOutput("reset_conf_a", a_conf, 0);
    checkOutput("reset_conf_b", b_conf, 0);

    // Writes/allocs to r3 held during the sweep must be ignored.
    a_wr_en = 1'b1; a_wr_addr = 5'd3; a_wr_data = 32'hFF; a_alloc_en = 1'b1; a_alloc_addr = 5'd3;
    b_wr_en = 2'b01; b_wr_addr = {5'd0, 5'd3}; b_wr_data = {32'h0, 32'hFF}; b_alloc_en = 1'b1; b_alloc_addr = 5'd3;
    a_rd_addr = {5'd0, 5'd3};
    @(negedge clk);
    rst = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      tick();
      if (e == 10) begin
        checkOutput("init_rd_zero", a_rd_data[31:0], 0);
        checkOutput("init_busy_zero", a_rd_busy[0], 0);
      end
      if (a_done && a_edges == 0) begin
        a_edges = e; a_wr_en = '0; a_alloc_en = 1'b0;
      end
      if (b_done && b_edges == 0) begin
        b_edges = e; b_wr_en = '0; b_alloc_en = 1'b0;
      end
    end
    checkOutput("sweep_edges_a", a_edges, 31);
    checkOutput("sweep_edges_b", b_edges, 23);

    for (int r = 0; r < 32; r++) begin
      a_rd_addr = {5'd0, 5'(r)};
      #1;
      checkOutput($sformatf("post_sweep_r%0d", r), a_rd_data[31:0], 0);
      checkOutput($sformatf("post_sweep_busy_r%0d", r), a_rd_busy[0], 0);
    end
    b_rd_addr = {5'd23, 5'd3};
    #1;
    checkOutput("b_r3_zero", b_rd_data[31:0], 0);
    checkOutput("b_r23_zero", b_rd_data[63:32], 0);
    checkOutput("b_r3_busy", b_rd_busy[0], 0);

    // Basic write/read without bypass.
    tick();
    a_wr_en = 1'b1; a_wr_addr = 5'd5; a_wr_data = 32'hDEADBEEF; a_rd_addr = {5'd0, 5'd5};
    @(negedge clk);
    checkOutput("a_r5_old", a_rd_data[31:0], 0);
    tick();
    a_wr_addr = 5'd0; a_wr_data = 32'h1234;
    @(negedge clk);
    checkOutput("a_r5_new", a_rd_data[31:0], 32'hDEADBEEF);
    checkOutput("a_r0_same", a_rd_data[63:32], 0);
    tick();
    applyStimulus();
    @(negedge clk);
    checkOutput("a_r0_after", a_rd_data[63:32], 0);

    // Scoreboard on r9.
    tick();
    a_alloc_en = 1'b1; a_alloc_addr = 5'd9; a_rd_addr = {5'd9, 5'd0};
    @(negedge clk);
    checkOutput("a_busy9_pre", a_rd_busy[1], 0);
    tick();
    applyStimulus();
    @(negedge clk);
    checkOutput("a_busy9_set", a_rd_busy[1], 1);
    tick();
    a_wr_en = 1'b1; a_wr_addr = 5'd9; a_wr_data = 32'h99;
    @(negedge clk);
    checkOutput("a_busy9_wrcycle", a_rd_busy[1], 1);
    tick();
    applyStimulus();
    @(negedge clk);
    checkOutput("a_busy9_clr", a_rd_busy[1], 0);
    checkOutput("a_r9_data", a_rd_data[63:32], 32'h99);
    tick();
    a_wr_en = 1'b1; a_wr_addr = 5'd9; a_wr_data = 32'h77; a_alloc_en = 1'b1; a_alloc_addr = 5'd9;
    tick();
    applyStimulus();
    @(negedge clk);
    checkOutput("a_busy9_alloc_wins", a_rd_busy[1], 1);
    checkOutput("a_r9_data2", a_rd_data[63:32], 32'h77);

    // Bypass and write collision on dut_b.
    tick();
    b_alloc_en = 1'b1; b_alloc_addr = 5'd7; b_rd_addr = {5'd0, 5'd7};
    tick();
    applyStimulus();
    @(negedge clk);
    checkOutput("b_busy7_set", b_rd_busy[0], 1);
    tick();
    b_wr_en = 2'b11; b_wr_addr = {5'd7, 5'd7}; b_wr_data = {32'h22, 32'h11};
    @(negedge clk);
    checkOutput("b_bypass7", b_rd_data[31:0], 32'h22);
    checkOutput("b_bypass_busy7", b_rd_busy[0], 0);
    checkOutput("b_conf_same", b_conf, 0);
    tick();
    applyStimulus();
    @(negedge clk);
    checkOutput("b_conf_pulse", b_conf, 1);
    checkOutput("b_r7_stored", b_rd_data[31:0], 32'h22);
    checkOutput("b_busy7_clr", b_rd_busy[0], 0);
    tick();
    b_wr_en = 2'b11; b_wr_addr = {5'd0, 5'd0}; b_wr_data = {32'h5, 32'h6}; b_rd_addr = {5'd0, 5'd0};
    @(negedge clk);
    checkOutput("b_conf_drop", b_conf, 0);
    checkOutput("b_r0_bypass", b_rd_data[31:0], 0);
    tick();
    b_wr_en = 2'b01; b_wr_addr = {5'd0, 5'd30}; b_wr_data = {32'h0, 32'h55};
    b_alloc_en = 1'b1; b_alloc_addr = 5'd30; b_rd_addr = {5'd30, 5'd0};
    @(negedge clk);
    checkOutput("b_r0_conf_none", b_conf, 0);
    checkOutput("b_oor_bypass", b_rd_data[63:32], 0);
    tick();
    applyStimulus();
    @(negedge clk);
    checkOutput("b_oor_data", b_rd_data[63:32], 0);
    checkOutput("b_oor_busy", b_rd_busy[1], 0);

    // Mid-run reset.
    tick();
    a_wr_en = 1'b1; a_wr_addr = 5'd4; a_wr_data = 32'hAA; a_rd_addr = {5'd0, 5'd4};
    tick();
    a_wr_en = 1'b0; a_alloc_en = 1'b1; a_alloc_addr = 5'd4;
    tick();
    applyStimulus();
    @(negedge clk);
    checkOutput("a_r4_pre", a_rd_data[31:0], 32'hAA);
    checkOutput("a_busy4_pre", a_rd_busy[0], 1);
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_done", a_done, 0);
    checkOutput("mid_rst_busy", a_rd_busy[0], 0);
    checkOutput("mid_rst_data", a_rd_data[31:0], 0);
    @(negedge clk);
    rst = 1'b1;
    a_edges = 0;
    for (int e = 1; e <= 40; e++) begin
      tick();
      if (a_done && a_edges == 0) a_edges = e;
    end
    checkOutput("resweep_edges", a_edges, 31);
    checkOutput("resweep_r4", a_rd_data[31:0], 0);
    checkOutput("resweep_busy4", a_rd_busy[0], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
